// File: rtl/pattern_tone_sequencer_if.sv
// pattern_tone_sequencer_if: control inputs and pattern/tone outputs of the sequencer
interface pattern_tone_sequencer_if #(parameter int SR_WIDTH = 6);
    logic                enable;
    logic [1:0]          mode;
    logic                din;
    logic [SR_WIDTH-1:0] pattern;
    logic                step_tick;
    logic                tone_out;
    modport master (output enable, mode, din, input pattern, step_tick, tone_out);
    modport slave  (input enable, mode, din, output pattern, step_tick, tone_out);
endinterface

// File: rtl/pattern_tone_sequencer.sv
// pattern_tone_sequencer: stepped pattern register driving a glitch-free square-wave oscillator (PATTERN_TONE_DIN_SYNC_EN adds 2-flop input synchronisers)
module pattern_tone_sequencer #(
    parameter int                  SR_WIDTH      = 6,
    parameter int                  PRESCALE_BITS = 20,
    parameter int                  PITCH_SHIFT   = 9,
    parameter int                  CNT_WIDTH     = 17,
    parameter logic [SR_WIDTH-1:0] TAP_MASK      = 6'b110000
) (
    input logic                      clk,
    input logic                      rst_n,
    pattern_tone_sequencer_if.slave  bus
);
    if (SR_WIDTH < 2 || SR_WIDTH > 16 || SR_WIDTH + PITCH_SHIFT > CNT_WIDTH) begin : g_bad_params
        $error("pattern_tone_sequencer: illegal SR_WIDTH/PITCH_SHIFT/CNT_WIDTH combination");
    end
    logic enable_s, din_s;
`ifdef PATTERN_TONE_DIN_SYNC_EN
    logic [1:0] enable_sync_q, din_sync_q;
    // two-flop synchronisers for the asynchronous user inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_sync_q <= '0;
            din_sync_q    <= '0;
        end else begin
            enable_sync_q <= {enable_sync_q[0], bus.enable};
            din_sync_q    <= {din_sync_q[0], bus.din};
        end
    end
    assign enable_s = enable_sync_q[1];
    assign din_s    = din_sync_q[1];
`else
    assign enable_s = bus.enable;
    assign din_s    = bus.din;
`endif
    logic [PRESCALE_BITS-1:0] presc_q, presc_d;
    logic [SR_WIDTH-1:0]      pattern_q, pattern_d;
    logic                     step_tick_q, tick, fb;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d, top_q, top_d, top_next;
    logic                     tone_q, tone_d, wrap;
    assign tick     = enable_s && (presc_q == '1);
    assign fb       = (pattern_q == '0) ? 1'b1 : ^(pattern_q & TAP_MASK);
    assign top_next = CNT_WIDTH'(pattern_q) << PITCH_SHIFT;
    assign wrap     = cnt_q >= top_q;
    // prescaler advance and pattern update selected by mode at the tick
    always_comb begin
        presc_d   = enable_s ? presc_q + 1'b1 : presc_q;
        pattern_d = !tick               ? pattern_q
                  : bus.mode == 2'b00   ? {din_s, pattern_q[SR_WIDTH-1:1]}
                  : bus.mode == 2'b01   ? {fb, pattern_q[SR_WIDTH-1:1]}
                  : bus.mode == 2'b10   ? pattern_q
                  :                       {pattern_q[0], pattern_q[SR_WIDTH-1:1]};
    end
    // oscillator: pitch is only reloaded at a wrap so half periods are never cut short
    always_comb begin
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        top_d  = wrap ? top_next : top_q;
        tone_d = wrap ? (top_q != '0) && !tone_q : tone_q;
    end
    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            pattern_q   <= '0;
            step_tick_q <= 1'b0;
            cnt_q       <= '0;
            top_q       <= '0;
            tone_q      <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            pattern_q   <= pattern_d;
            step_tick_q <= tick;
            cnt_q       <= cnt_d;
            top_q       <= top_d;
            tone_q      <= tone_d;
        end
    end
    assign bus.pattern   = pattern_q;
    assign bus.step_tick = step_tick_q;
    assign bus.tone_out  = tone_q;
endmodule

// File: tb/tb_pattern_tone_sequencer.sv
// tb_pattern_tone_sequencer: scoreboard bench with a transaction-level reference model
module tb_pattern_tone_sequencer;
    localparam int W = 6, PB = 3, PS = 2, CW = 8;
    logic clk = 1'b0, rst_n = 1'b1;
    always #5 clk = ~clk;
    pattern_tone_sequencer_if #(.SR_WIDTH(W)) bus();
    pattern_tone_sequencer #(.SR_WIDTH(W), .PRESCALE_BITS(PB), .PITCH_SHIFT(PS), .CNT_WIDTH(CW),
                             .TAP_MASK(6'b110000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    typedef struct {int c; logic [W-1:0] v;} ev_t;
    ev_t tick_q[$], tone_q[$], e;
    int n_cmp = 0, n_bad = 0, cyc = 0;
    int en_cnt, top_m, rem;
    logic [W-1:0] pat_m;
    logic tone_m, nt, prev_tone = 1'b0;

    function automatic logic [W-1:0] next_pat(input logic [W-1:0] p, input logic [1:0] m, input logic d);
        logic [W-1:0] taps = 6'b110000;
        int fbit = (p == 0) ? 1 : $countones(p & taps) % 2;
        case (m)
            2'd0:    return (p >> 1) | (W'(d) << (W - 1));
            2'd1:    return (p >> 1) | (W'(fbit) << (W - 1));
            2'd2:    return p;
            default: return (p >> 1) | (W'(p[0]) << (W - 1));
        endcase
    endfunction

    // reference model: enabled-cycle count gives ticks, half periods last (pattern<<PS)+1 cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_cnt = 0; pat_m = '0; top_m = 0; rem = 1; tone_m = 1'b0;
            tick_q.delete(); tone_q.delete();
        end else begin
            cyc++;
            rem--;
            if (rem == 0) begin
                nt = (top_m != 0) ? ~tone_m : 1'b0;
                if (nt != tone_m) tone_q.push_back('{cyc, W'(nt)});
                tone_m = nt;
                top_m = int'(pat_m) * (1 << PS);
                rem = top_m + 1;
            end
            if (bus.enable) begin
                en_cnt++;
                if (en_cnt == (1 << PB)) begin
                    en_cnt = 0;
                    pat_m = next_pat(pat_m, bus.mode, bus.din);
                    tick_q.push_back('{cyc, pat_m});
                end
            end
        end
    end

    // monitor: pops expectations when the DUT ticks or its tone changes
    always @(negedge clk) begin
        if (!rst_n) prev_tone = 1'b0;
        else begin
            while (tick_q.size() != 0 && tick_q[0].c < cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL tick_missing: expected tick at cycle %0d pattern %b, not observed", tick_q[0].c, tick_q[0].v);
                void'(tick_q.pop_front());
            end
            while (tone_q.size() != 0 && tone_q[0].c < cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL tone_missing: expected tone=%0b at cycle %0d, not observed", tone_q[0].v[0], tone_q[0].c);
                void'(tone_q.pop_front());
            end
            if (bus.step_tick === 1'b1) begin
                n_cmp++;
                if (tick_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL tick_unexpected: cycle %0d got pattern %b, no tick expected", cyc, bus.pattern);
                end else begin
                    e = tick_q.pop_front();
                    if (e.c != cyc || e.v !== bus.pattern) begin
                        n_bad++;
                        $display("FAIL tick: cycle %0d pattern %b, expected cycle %0d pattern %b", cyc, bus.pattern, e.c, e.v);
                    end
                end
            end
            if (bus.tone_out !== prev_tone) begin
                n_cmp++;
                if (tone_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL tone_unexpected: cycle %0d tone=%b, no change expected", cyc, bus.tone_out);
                end else begin
                    e = tone_q.pop_front();
                    if (e.c != cyc || e.v[0] !== bus.tone_out) begin
                        n_bad++;
                        $display("FAIL tone: cycle %0d tone=%b, expected cycle %0d tone=%b", cyc, bus.tone_out, e.c, e.v[0]);
                    end
                end
                prev_tone = bus.tone_out;
            end
        end
    end

    task automatic check_zero(input string nm);
        n_cmp++;
        if (bus.pattern !== '0 || bus.step_tick !== 1'b0 || bus.tone_out !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: pattern=%b step_tick=%b tone_out=%b, expected all zero", nm, bus.pattern, bus.step_tick, bus.tone_out);
        end
    endtask

    task automatic drive(input logic en, input logic [1:0] m, input logic d, input int n);
        @(negedge clk);
        bus.enable = en; bus.mode = m; bus.din = d;
        repeat (n - 1) @(negedge clk);
    endtask

    initial begin
        bus.enable = 1'b0; bus.mode = 2'b00; bus.din = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_zero("reset_initial");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        drive(1, 2'b00, 1, 24);
        drive(1, 2'b00, 0, 48);
        drive(1, 2'b01, 0, 64 * 8);
        drive(1, 2'b10, 0, 400);
        drive(0, 2'b11, 0, 100);
        drive(1, 2'b11, 0, 64);
        drive(1, 2'b10, 1, 300);
        repeat (3000) begin
            @(negedge clk);
            bus.enable = ($urandom_range(0, 9) != 0);
            bus.mode   = 2'($urandom_range(0, 3));
            bus.din    = 1'($urandom);
        end
        drive(1, 2'b00, 1, 24);
        drive(1, 2'b10, 0, 200);
        #2 rst_n = 1'b0;
        #1 check_zero("reset_midrun");
        @(negedge clk);
        #1 check_zero("reset_held");
        #1 rst_n = 1'b1;
        drive(1, 2'b01, 0, 400);
        repeat (200) begin
            @(negedge clk);
            bus.enable = ($urandom_range(0, 3) != 0);
            bus.mode   = 2'($urandom_range(0, 3));
            bus.din    = 1'($urandom);
        end
        drive(0, 2'b10, 0, 3);
        #1;
        n_cmp++;
        if (tick_q.size() != 0) begin
            n_bad++;
            $display("FAIL tick_drain: %0d ticks outstanding, expected 0", tick_q.size());
        end
        n_cmp++;
        if (tone_q.size() != 0) begin
            n_bad++;
            $display("FAIL tone_drain: %0d tone edges outstanding, expected 0", tone_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
